// File: rtl/acorn128_job_sched.sv
// acorn128_job_sched: shares one acorn128_top core between two requesters.
// Round-robin grant, one job in flight; each job resets the core, holds start
// until the core reports ready (or a timeout expires) and returns a single
// response tagged with the requester id.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a request; grant visible combinationally
// S_CRST  | one-cycle core reset pulse with the job fields already latched
// S_START | core start raised; counter cleared; core ready not yet trusted
// S_WAIT  | start held; counting toward timeout; capture result on ready
// S_RESP  | response presented and held until the consumer accepts it
module acorn128_job_sched #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid_in,
    output logic         req0_ready_out,
    input  logic         req0_encrypt_in,
    input  logic [127:0] req0_key_in,
    input  logic [127:0] req0_iv_in,
    input  logic [127:0] req0_data_in,
    input  logic [127:0] req0_ad_in,
    input  logic [63:0]  req0_len_in,
    input  logic [127:0] req0_tag_in,
    input  logic         req1_valid_in,
    output logic         req1_ready_out,
    input  logic         req1_encrypt_in,
    input  logic [127:0] req1_key_in,
    input  logic [127:0] req1_iv_in,
    input  logic [127:0] req1_data_in,
    input  logic [127:0] req1_ad_in,
    input  logic [63:0]  req1_len_in,
    input  logic [127:0] req1_tag_in,
    output logic         core_rst_out,
    output logic         core_start_out,
    output logic         core_encrypt_out,
    output logic [127:0] core_key_out,
    output logic [127:0] core_iv_out,
    output logic [127:0] core_data_out,
    output logic [127:0] core_ad_out,
    output logic [63:0]  core_len_out,
    input  logic [127:0] core_text_in,
    input  logic [127:0] core_tag_in,
    input  logic         core_ready_in,
    output logic         rsp_valid_out,
    input  logic         rsp_ready_in,
    output logic         rsp_id_out,
    output logic [127:0] rsp_data_out,
    output logic [127:0] rsp_tag_out,
    output logic         rsp_auth_ok_out,
    output logic         rsp_timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] L_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic             r_last_grant;
    logic             r_crst;
    logic             r_start;
    logic [CNT_W-1:0] r_cnt;
    logic             r_id;
    logic             r_encrypt;
    logic [127:0]     r_key;
    logic [127:0]     r_iv;
    logic [127:0]     r_data;
    logic [127:0]     r_ad;
    logic [63:0]      r_len;
    logic [127:0]     r_exp_tag;
    logic             r_rsp_valid;
    logic [127:0]     r_rsp_data;
    logic [127:0]     r_rsp_tag;
    logic             r_rsp_auth_ok;
    logic             r_rsp_timeout;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_hs;
    logic             w_sel;

    // On contention the requester that was not granted last time wins.
    assign w_idle = (r_state == S_IDLE);
    assign w_gnt0 = req0_valid_in & (~req1_valid_in | r_last_grant);
    assign w_gnt1 = req1_valid_in & (~req0_valid_in | ~r_last_grant);
    assign req0_ready_out = w_idle & w_gnt0;
    assign req1_ready_out = w_idle & w_gnt1;
    assign w_hs  = req0_ready_out | req1_ready_out;
    assign w_sel = req1_ready_out;

    // Core stays in reset for as long as the scheduler itself is in reset.
    assign core_rst_out     = rst | r_crst;
    assign core_start_out   = r_start;
    assign core_encrypt_out = r_encrypt;
    assign core_key_out     = r_key;
    assign core_iv_out      = r_iv;
    assign core_data_out    = r_data;
    assign core_ad_out      = r_ad;
    assign core_len_out     = r_len;

    assign rsp_valid_out   = r_rsp_valid;
    assign rsp_id_out      = r_id;
    assign rsp_data_out    = r_rsp_data;
    assign rsp_tag_out     = r_rsp_tag;
    assign rsp_auth_ok_out = r_rsp_auth_ok;
    assign rsp_timeout_out = r_rsp_timeout;

    // Job sequencing FSM with registered core controls and response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_crst        <= 1'b0;
            r_start       <= 1'b0;
            r_cnt         <= '0;
            r_id          <= 1'b0;
            r_encrypt     <= 1'b0;
            r_key         <= '0;
            r_iv          <= '0;
            r_data        <= '0;
            r_ad          <= '0;
            r_len         <= '0;
            r_exp_tag     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_tag     <= '0;
            r_rsp_auth_ok <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_id         <= w_sel;
                        r_last_grant <= w_sel;
                        r_encrypt    <= w_sel ? req1_encrypt_in : req0_encrypt_in;
                        r_key        <= w_sel ? req1_key_in     : req0_key_in;
                        r_iv         <= w_sel ? req1_iv_in      : req0_iv_in;
                        r_data       <= w_sel ? req1_data_in    : req0_data_in;
                        r_ad         <= w_sel ? req1_ad_in      : req0_ad_in;
                        r_len        <= w_sel ? req1_len_in     : req0_len_in;
                        r_exp_tag    <= w_sel ? req1_tag_in     : req0_tag_in;
                        r_crst       <= 1'b1;
                        r_state      <= S_CRST;
                    end
                end
                S_CRST: begin
                    r_crst  <= 1'b0;
                    r_start <= 1'b1;
                    r_state <= S_START;
                end
                S_START: begin
                    // Ready from the core is stale until it has seen start.
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_ready_in) begin
                        r_rsp_data    <= core_text_in;
                        r_rsp_tag     <= core_tag_in;
                        r_rsp_auth_ok <= r_encrypt | (core_tag_in == r_exp_tag);
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_start       <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (r_cnt == L_TERM) begin
                        r_rsp_data    <= '0;
                        r_rsp_tag     <= '0;
                        r_rsp_auth_ok <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_start       <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready_in) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_crst      <= 1'b0;
                    r_start     <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_job_sched.sv
// Directed bench for acorn128_job_sched with a small behavioural core model.
module tb_acorn128_job_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid_in, req0_ready_out, req0_encrypt_in;
    logic [127:0] req0_key_in, req0_iv_in, req0_data_in, req0_ad_in, req0_tag_in;
    logic [63:0]  req0_len_in;
    logic         req1_valid_in, req1_ready_out, req1_encrypt_in;
    logic [127:0] req1_key_in, req1_iv_in, req1_data_in, req1_ad_in, req1_tag_in;
    logic [63:0]  req1_len_in;
    logic         core_rst_out, core_start_out, core_encrypt_out;
    logic [127:0] core_key_out, core_iv_out, core_data_out, core_ad_out;
    logic [63:0]  core_len_out;
    logic [127:0] core_text_in, core_tag_in;
    logic         core_ready_in;
    logic         rsp_valid_out, rsp_ready_in, rsp_id_out;
    logic [127:0] rsp_data_out, rsp_tag_out;
    logic         rsp_auth_ok_out, rsp_timeout_out;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] K   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] IV  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] PT  = 128'hAABBCCDDEEFF00112233445566778899;
    localparam logic [127:0] AD  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] D2  = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
    localparam logic [63:0]  LEN = 64'd16;

    always #5 clk = ~clk;

    acorn128_job_sched #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid_in(req0_valid_in), .req0_ready_out(req0_ready_out),
        .req0_encrypt_in(req0_encrypt_in), .req0_key_in(req0_key_in),
        .req0_iv_in(req0_iv_in), .req0_data_in(req0_data_in),
        .req0_ad_in(req0_ad_in), .req0_len_in(req0_len_in), .req0_tag_in(req0_tag_in),
        .req1_valid_in(req1_valid_in), .req1_ready_out(req1_ready_out),
        .req1_encrypt_in(req1_encrypt_in), .req1_key_in(req1_key_in),
        .req1_iv_in(req1_iv_in), .req1_data_in(req1_data_in),
        .req1_ad_in(req1_ad_in), .req1_len_in(req1_len_in), .req1_tag_in(req1_tag_in),
        .core_rst_out(core_rst_out), .core_start_out(core_start_out),
        .core_encrypt_out(core_encrypt_out), .core_key_out(core_key_out),
        .core_iv_out(core_iv_out), .core_data_out(core_data_out),
        .core_ad_out(core_ad_out), .core_len_out(core_len_out),
        .core_text_in(core_text_in), .core_tag_in(core_tag_in),
        .core_ready_in(core_ready_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_id_out(rsp_id_out), .rsp_data_out(rsp_data_out),
        .rsp_tag_out(rsp_tag_out), .rsp_auth_ok_out(rsp_auth_ok_out),
        .rsp_timeout_out(rsp_timeout_out)
    );

    // Toy core: keystream XOR for text, tag computed over the plaintext.
    function automatic logic [127:0] ksf(input logic [127:0] k, input logic [127:0] iv,
                                         input logic [127:0] ad);
        return k ^ {iv[63:0], iv[127:64]} ^ ~ad;
    endfunction

    function automatic logic [127:0] tagf(input logic [127:0] pt, input logic [127:0] k,
                                          input logic [127:0] iv, input logic [127:0] ad,
                                          input logic [63:0] len);
        return (pt + k) ^ iv ^ {len, len} ^ {ad[63:0], ad[127:64]};
    endfunction

    int   m_lat;
    int   m_cnt;
    logic m_rdy;
    logic m_force;

    // Core model raises ready m_lat cycles after seeing start; m_lat==0 never does.
    always @(posedge clk) begin
        if (core_rst_out) begin
            m_cnt <= 0;
            m_rdy <= 1'b0;
        end else if (core_start_out && m_lat != 0 && !m_rdy) begin
            if (m_cnt == m_lat - 1) m_rdy <= 1'b1;
            else                    m_cnt <= m_cnt + 1;
        end
    end

    assign core_ready_in = m_force | m_rdy;
    assign core_text_in  = core_data_out ^ ksf(core_key_out, core_iv_out, core_ad_out);
    assign core_tag_in   = tagf(core_encrypt_out ? core_data_out : core_text_in,
                                core_key_out, core_iv_out, core_ad_out, core_len_out);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic enc,
                           input logic [127:0] d, input logic [127:0] tg);
        if (n == 0) begin
            req0_valid_in = v; req0_encrypt_in = enc; req0_key_in = K; req0_iv_in = IV;
            req0_data_in = d; req0_ad_in = AD; req0_len_in = LEN; req0_tag_in = tg;
        end else begin
            req1_valid_in = v; req1_encrypt_in = enc; req1_key_in = K; req1_iv_in = IV;
            req1_data_in = d; req1_ad_in = AD; req1_len_in = LEN; req1_tag_in = tg;
        end
    endtask

    task automatic wait_rsp(input int max, output int n);
        n = 0;
        while (!rsp_valid_out && n < max) begin
            step();
            n++;
        end
        chk("rsp_arrived", 128'(rsp_valid_out), 128'(1));
    endtask

    task automatic finish_rsp();
        rsp_ready_in = 1'b1;
        step();
        rsp_ready_in = 1'b0;
        chk("rsp_released", 128'(rsp_valid_out), 128'(0));
    endtask

    // Handshake happens at the first step; optionally drop both valids afterwards.
    task automatic run_job(input bit drop);
        int n;
        step();
        if (drop) begin
            req0_valid_in = 1'b0;
            req1_valid_in = 1'b0;
        end
        wait_rsp(60, n);
    endtask

    initial begin
        int n;
        logic [127:0] ct, tg, held;
        logic seen;
        rst = 1'b1; rsp_ready_in = 1'b0; m_lat = 3; m_force = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step(); step(); step();
        chk("rst_core_rst", 128'(core_rst_out), 128'(1));
        chk("rst_rsp_valid", 128'(rsp_valid_out), 128'(0));
        chk("rst_start", 128'(core_start_out), 128'(0));
        chk("rst_key", core_key_out, 128'(0));
        rst = 1'b0;
        step();
        chk("idle_core_rst", 128'(core_rst_out), 128'(0));

        // Encrypt job on requester 0
        set_req(0, 1'b1, 1'b1, PT, '0);
        #1;
        chk("enc_rdy0", 128'(req0_ready_out), 128'(1));
        chk("enc_rdy1", 128'(req1_ready_out), 128'(0));
        step();
        req0_valid_in = 1'b0;
        req0_data_in  = ~PT;
        req0_key_in   = '1;
        #1;
        chk("crst_pulse", 128'(core_rst_out), 128'(1));
        chk("crst_start", 128'(core_start_out), 128'(0));
        chk("latched_data", core_data_out, PT);
        chk("latched_key", core_key_out, K);
        chk("latched_enc", 128'(core_encrypt_out), 128'(1));
        chk("no_rdy_busy", 128'(req0_ready_out), 128'(0));
        step();
        chk("start_crst_low", 128'(core_rst_out), 128'(0));
        chk("start_high", 128'(core_start_out), 128'(1));
        step();
        chk("wait_start_held", 128'(core_start_out), 128'(1));
        wait_rsp(60, n);
        chk("enc_latency", 128'(n), 128'(3));
        chk("enc_id", 128'(rsp_id_out), 128'(0));
        chk("enc_auth", 128'(rsp_auth_ok_out), 128'(1));
        chk("enc_timeout", 128'(rsp_timeout_out), 128'(0));
        chk("enc_data", rsp_data_out, PT ^ ksf(K, IV, AD));
        chk("enc_tag", rsp_tag_out, tagf(PT, K, IV, AD, LEN));
        chk("resp_start_low", 128'(core_start_out), 128'(0));
        ct = PT ^ ksf(K, IV, AD);
        tg = tagf(PT, K, IV, AD, LEN);

        // Response back-pressure with both requesters knocking
        set_req(0, 1'b1, 1'b1, D2, '0);
        set_req(1, 1'b1, 1'b0, ct, tg);
        held = rsp_data_out;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 128'(rsp_valid_out), 128'(1));
            chk("hold_data", rsp_data_out, ct);
            chk("hold_rdy", 128'({req0_ready_out, req1_ready_out}), 128'(0));
        end
        chk("hold_data_end", rsp_data_out, held);
        req0_valid_in = 1'b0;
        finish_rsp();

        // Decrypt of the ciphertext on requester 1
        chk("dec_rdy1", 128'(req1_ready_out), 128'(1));
        run_job(1'b1);
        chk("dec_id", 128'(rsp_id_out), 128'(1));
        chk("dec_data", rsp_data_out, PT);
        chk("dec_auth", 128'(rsp_auth_ok_out), 128'(1));
        chk("dec_tag", rsp_tag_out, tg);
        finish_rsp();

        // Same decrypt with a corrupted expected tag
        set_req(1, 1'b1, 1'b0, ct, tg ^ 128'd1);
        #1;
        run_job(1'b1);
        chk("bad_data", rsp_data_out, PT);
        chk("bad_auth", 128'(rsp_auth_ok_out), 128'(0));
        chk("bad_timeout", 128'(rsp_timeout_out), 128'(0));
        finish_rsp();

        // Contention straight out of reset: 0, then 1, then 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b1, PT, '0);
        set_req(1, 1'b1, 1'b1, D2, '0);
        #1;
        chk("arb_a_rdy", 128'({req0_ready_out, req1_ready_out}), 128'(2'b10));
        run_job(1'b0);
        chk("arb_a_id", 128'(rsp_id_out), 128'(0));
        chk("arb_a_data", rsp_data_out, PT ^ ksf(K, IV, AD));
        finish_rsp();
        chk("arb_b_rdy", 128'({req0_ready_out, req1_ready_out}), 128'(2'b01));
        run_job(1'b0);
        chk("arb_b_id", 128'(rsp_id_out), 128'(1));
        chk("arb_b_data", rsp_data_out, D2 ^ ksf(K, IV, AD));
        finish_rsp();
        chk("arb_c_rdy", 128'({req0_ready_out, req1_ready_out}), 128'(2'b10));
        run_job(1'b1);
        chk("arb_c_id", 128'(rsp_id_out), 128'(0));
        finish_rsp();

        // Core never answers: timeout after 16 WAIT cycles
        m_lat = 0;
        set_req(0, 1'b1, 1'b1, PT, '0);
        #1;
        step();
        req0_valid_in = 1'b0;
        step();
        step();
        wait_rsp(40, n);
        chk("to_cycles", 128'(n), 128'(16));
        chk("to_flag", 128'(rsp_timeout_out), 128'(1));
        chk("to_data", rsp_data_out, 128'(0));
        chk("to_tag", rsp_tag_out, 128'(0));
        chk("to_auth", 128'(rsp_auth_ok_out), 128'(0));
        finish_rsp();

        // Ready already high during START must not shortcut WAIT
        m_force = 1'b1;
        set_req(1, 1'b1, 1'b1, D2, '0);
        #1;
        chk("lat_rdy1", 128'(req1_ready_out), 128'(1));
        step();
        req1_valid_in = 1'b0;
        step();
        chk("lat_c2_valid", 128'(rsp_valid_out), 128'(0));
        chk("lat_c2_start", 128'(core_start_out), 128'(1));
        step();
        chk("lat_c3_valid", 128'(rsp_valid_out), 128'(0));
        step();
        chk("lat_c4_valid", 128'(rsp_valid_out), 128'(1));
        chk("lat_id", 128'(rsp_id_out), 128'(1));
        chk("lat_data", rsp_data_out, D2 ^ ksf(K, IV, AD));
        finish_rsp();
        m_force = 1'b0;

        // Reset while waiting aborts the job silently
        set_req(0, 1'b1, 1'b1, PT, '0);
        #1;
        step();
        req0_valid_in = 1'b0;
        step(); step(); step();
        chk("abort_in_wait", 128'(core_start_out), 128'(1));
        rst = 1'b1;
        step();
        chk("abort_start", 128'(core_start_out), 128'(0));
        chk("abort_valid", 128'(rsp_valid_out), 128'(0));
        chk("abort_core_rst", 128'(core_rst_out), 128'(1));
        chk("abort_key", core_key_out, 128'(0));
        chk("abort_data", core_data_out, 128'(0));
        chk("abort_rsp_data", rsp_data_out, 128'(0));
        chk("abort_rsp_id", 128'(rsp_id_out), 128'(0));
        rst = 1'b0;
        step();
        chk("abort_core_rst_low", 128'(core_rst_out), 128'(0));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (rsp_valid_out) seen = 1'b1;
        end
        chk("abort_no_rsp", 128'(seen), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
